// File: rtl/b2oh_stream_if.sv
// Valid/ready stream bundle for b2oh_stream: binary code in, positional code out.
// The block is the slave; the control source and the output consumer together form the master.
interface b2oh_stream_if #(
   parameter int IN_W  = 3,
   parameter int OUT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  datain;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] dataout;
   logic             out_err;

   modport master (
      output in_valid, datain, out_ready,
      input  in_ready, out_valid, dataout, out_err
   );

   modport slave (
      input  in_valid, datain, out_ready,
      output in_ready, out_valid, dataout, out_err
   );
endinterface

// File: rtl/b2oh_stream.sv
// Registered binary to positional-code converter (one-hot, thermometer, active-low one-hot)
// with an autonomous scan mode that walks one active bit at a programmable dwell.
module b2oh_stream #(
   parameter int IN_W    = 3,
   parameter int OUT_W   = 8,
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         mode,
   input  logic [DWELL_W-1:0] dwell,
   b2oh_stream_if.slave       bus
);
   typedef enum logic [1:0] {
      MODE_ONEHOT   = 2'd0,
      MODE_THERM    = 2'd1,
      MODE_ONEHOT_N = 2'd2,
      MODE_SCAN     = 2'd3
   } mode_e;

   localparam int                POS_W    = (OUT_W > 2) ? $clog2(OUT_W) : 1;
   localparam logic [IN_W:0]     OUT_W_L  = (IN_W+1)'(OUT_W);
   localparam logic [POS_W-1:0]  POS_LAST = POS_W'(OUT_W-1);

   mode_e              mode_in, mode_q;
   logic               out_valid_q, out_valid_d;
   logic [OUT_W-1:0]   dataout_q, dataout_d;
   logic               out_err_q, out_err_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d, cnt_last;
   logic               slot_free, scan, entry, accept, emit, in_range;
   logic [OUT_W-1:0]   onehot, therm, scan_code;

   assign mode_in      = mode_e'(mode);
   assign scan         = (mode_in == MODE_SCAN);
   assign entry        = scan && (mode_q != MODE_SCAN);
   assign slot_free    = !out_valid_q || bus.out_ready;
   assign bus.in_ready = slot_free && !scan;
   assign accept       = bus.in_valid && bus.in_ready;
   assign in_range     = {1'b0, bus.datain} < OUT_W_L;
   // A dwell of 0 behaves as 1, so the terminal count saturates at 0.
   assign cnt_last     = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
   // >= rather than == lets a shortened dwell take effect on the next free slot.
   assign emit         = scan && !entry && (cnt_q >= cnt_last) && slot_free;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      onehot    = '0;
      therm     = '0;
      scan_code = '0;
      for (int i = 0; i < OUT_W; i++) begin
         onehot[i]    = (bus.datain == IN_W'(i));
         therm[i]     = in_range && (IN_W'(i) <= bus.datain);
         scan_code[i] = (pos_q == POS_W'(i));
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      dataout_d   = dataout_q;
      out_err_d   = out_err_q;
      pos_d       = pos_q;
      cnt_d       = cnt_q;

      if (accept) begin
         out_valid_d = 1'b1;
         out_err_d   = !in_range;
         unique case (mode_in)
            MODE_THERM:    dataout_d = therm;
            MODE_ONEHOT_N: dataout_d = ~onehot;
            default:       dataout_d = onehot;
         endcase
      end else if (emit) begin
         out_valid_d = 1'b1;
         out_err_d   = 1'b0;
         dataout_d   = scan_code;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      if (entry) begin
         cnt_d = '0;
         pos_d = '0;
      end else if (scan) begin
         if (cnt_q >= cnt_last) begin
            if (slot_free) begin
               cnt_d = '0;
               pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
            end
         end else begin
            cnt_d = cnt_q + DWELL_W'(1);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q      <= MODE_ONEHOT;
         out_valid_q <= 1'b0;
         dataout_q   <= '0;
         out_err_q   <= 1'b0;
         pos_q       <= '0;
         cnt_q       <= '0;
      end else begin
         mode_q      <= mode_in;
         out_valid_q <= out_valid_d;
         dataout_q   <= dataout_d;
         out_err_q   <= out_err_d;
         pos_q       <= pos_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.dataout   = dataout_q;
   assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_b2oh_stream.sv
// Directed bench for b2oh_stream: three instances (OUT_W = 8, 6, 4) share one stimulus,
// each is compared against hand-computed codes for its own output width.
module tb_b2oh_stream;
   logic        clk;
   logic        rst_n;
   logic [1:0]  mode;
   logic [15:0] dwell;
   logic        in_valid;
   logic [2:0]  datain;
   logic        out_ready;

   int errors = 0;
   int checks = 0;

   b2oh_stream_if #(.IN_W(3), .OUT_W(8)) if8 ();
   b2oh_stream_if #(.IN_W(3), .OUT_W(6)) if6 ();
   b2oh_stream_if #(.IN_W(3), .OUT_W(4)) if4 ();

   assign if8.in_valid = in_valid;  assign if8.datain = datain;  assign if8.out_ready = out_ready;
   assign if6.in_valid = in_valid;  assign if6.datain = datain;  assign if6.out_ready = out_ready;
   assign if4.in_valid = in_valid;  assign if4.datain = datain;  assign if4.out_ready = out_ready;

   b2oh_stream #(.IN_W(3), .OUT_W(8), .DWELL_W(16)) u8 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .dwell(dwell), .bus(if8.slave));
   b2oh_stream #(.IN_W(3), .OUT_W(6), .DWELL_W(16)) u6 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .dwell(dwell), .bus(if6.slave));
   b2oh_stream #(.IN_W(3), .OUT_W(4), .DWELL_W(16)) u4 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .dwell(dwell), .bus(if4.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [1:0] mode;
      logic [2:0] din;
      logic [7:0] exp8;
      logic       err8;
      logic [5:0] exp6;
      logic       err6;
   } vec_t;

   vec_t vecs[16];

   initial begin
      vecs[0]  = '{2'd0, 3'd0, 8'h01, 1'b0, 6'h01, 1'b0};
      vecs[1]  = '{2'd0, 3'd1, 8'h02, 1'b0, 6'h02, 1'b0};
      vecs[2]  = '{2'd0, 3'd2, 8'h04, 1'b0, 6'h04, 1'b0};
      vecs[3]  = '{2'd0, 3'd3, 8'h08, 1'b0, 6'h08, 1'b0};
      vecs[4]  = '{2'd0, 3'd4, 8'h10, 1'b0, 6'h10, 1'b0};
      vecs[5]  = '{2'd0, 3'd5, 8'h20, 1'b0, 6'h20, 1'b0};
      vecs[6]  = '{2'd0, 3'd6, 8'h40, 1'b0, 6'h00, 1'b1};
      vecs[7]  = '{2'd0, 3'd7, 8'h80, 1'b0, 6'h00, 1'b1};
      vecs[8]  = '{2'd1, 3'd3, 8'h0F, 1'b0, 6'h0F, 1'b0};
      vecs[9]  = '{2'd1, 3'd7, 8'hFF, 1'b0, 6'h00, 1'b1};
      vecs[10] = '{2'd1, 3'd0, 8'h01, 1'b0, 6'h01, 1'b0};
      vecs[11] = '{2'd1, 3'd5, 8'h3F, 1'b0, 6'h3F, 1'b0};
      vecs[12] = '{2'd2, 3'd5, 8'hDF, 1'b0, 6'h1F, 1'b0};
      vecs[13] = '{2'd2, 3'd7, 8'h7F, 1'b0, 6'h3F, 1'b1};
      vecs[14] = '{2'd2, 3'd0, 8'hFE, 1'b0, 6'h3E, 1'b0};
      vecs[15] = '{2'd0, 3'd5, 8'h20, 1'b0, 6'h20, 1'b0};

      rst_n     = 1'b0;
      mode      = 2'd0;
      dwell     = 16'd0;
      in_valid  = 1'b1;
      datain    = 3'($urandom_range(0, 7));
      out_ready = 1'b0;

      // Reset holds everything at zero despite a valid input.
      repeat (3) tick();
      check("rst out_valid u8", 32'(if8.out_valid), 32'd0);
      check("rst dataout u8",   32'(if8.dataout),   32'd0);
      check("rst out_err u8",   32'(if8.out_err),   32'd0);
      check("rst dataout u6",   32'(if6.dataout),   32'd0);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      #1;
      check("post-rst in_ready", 32'(if8.in_ready), 32'd1);

      // Back-to-back decode sweep, one code per cycle.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 16; i++) begin
         mode   = vecs[i].mode;
         datain = vecs[i].din;
         tick();
         check($sformatf("vec%0d out_valid u8", i), 32'(if8.out_valid), 32'd1);
         check($sformatf("vec%0d dataout u8", i),   32'(if8.dataout),   32'(vecs[i].exp8));
         check($sformatf("vec%0d out_err u8", i),   32'(if8.out_err),   32'(vecs[i].err8));
         check($sformatf("vec%0d dataout u6", i),   32'(if6.dataout),   32'(vecs[i].exp6));
         check($sformatf("vec%0d out_err u6", i),   32'(if6.out_err),   32'(vecs[i].err6));
      end
      in_valid = 1'b0;
      tick();
      check("drain out_valid", 32'(if8.out_valid), 32'd0);

      // Backpressure: held output is stable, then consume and accept on the same edge.
      mode     = 2'd0;
      in_valid = 1'b1;
      datain   = 3'd2;
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         check($sformatf("bp%0d in_ready", c),  32'(if8.in_ready),  32'd0);
         check($sformatf("bp%0d dataout", c),   32'(if8.dataout),   32'h04);
         check($sformatf("bp%0d out_valid", c), 32'(if8.out_valid), 32'd1);
         tick();
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      datain    = 3'd4;
      #1;
      check("bp release in_ready", 32'(if8.in_ready), 32'd1);
      tick();
      check("bp next dataout",   32'(if8.dataout),   32'h10);
      check("bp next out_valid", 32'(if8.out_valid), 32'd1);
      in_valid = 1'b0;
      tick();
      check("bp drain", 32'(if8.out_valid), 32'd0);

      // Scan with dwell 3: emissions at entry edge + 3, 6, 9, ...
      mode     = 2'd3;
      dwell    = 16'd3;
      in_valid = 1'b1;
      datain   = 3'd5;
      #1;
      check("scan in_ready", 32'(if4.in_ready), 32'd0);
      for (int k = 0; k < 16; k++) begin
         tick();
         if (k > 0 && k % 3 == 0) begin
            check($sformatf("scan3 k%0d valid", k), 32'(if4.out_valid), 32'd1);
            check($sformatf("scan3 k%0d data", k),  32'(if4.dataout),   32'(1 << ((k / 3 - 1) % 4)));
         end else begin
            check($sformatf("scan3 k%0d valid", k), 32'(if4.out_valid), 32'd0);
         end
      end
      in_valid = 1'b0;
      mode     = 2'd0;
      tick();
      check("scan3 exit drain", 32'(if4.out_valid), 32'd0);

      // Scan with dwell 0 behaves as dwell 1: one emission per cycle.
      mode  = 2'd3;
      dwell = 16'd0;
      for (int k = 0; k < 6; k++) begin
         tick();
         check($sformatf("scan0 k%0d valid", k), 32'(if4.out_valid), (k > 0) ? 32'd1 : 32'd0);
         if (k > 0)
            check($sformatf("scan0 k%0d data", k), 32'(if4.dataout), 32'(1 << ((k - 1) % 4)));
      end
      mode = 2'd0;
      tick();

      // Scan stall with dwell 2: 0x1 is held, the next step is 0x2 with nothing skipped.
      mode  = 2'd3;
      dwell = 16'd2;
      tick();
      check("stall k0 valid", 32'(if4.out_valid), 32'd0);
      tick();
      check("stall k1 valid", 32'(if4.out_valid), 32'd0);
      tick();
      check("stall k2 data", 32'(if4.dataout), 32'h1);
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         check($sformatf("stall hold%0d data", c),  32'(if4.dataout),   32'h1);
         check($sformatf("stall hold%0d valid", c), 32'(if4.out_valid), 32'd1);
      end
      out_ready = 1'b1;
      tick();
      check("stall next data",  32'(if4.dataout),   32'h2);
      check("stall next valid", 32'(if4.out_valid), 32'd1);

      // Leave scan with the output held: no accept until consumed, and scanning stops.
      mode      = 2'd0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      datain    = 3'd1;
      #1;
      check("exit held in_ready", 32'(if4.in_ready), 32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("exit hold%0d data", c), 32'(if4.dataout), 32'h2);
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      #1;
      check("exit consume in_ready", 32'(if4.in_ready), 32'd1);
      for (int c = 0; c < 4; c++) begin
         tick();
         check($sformatf("exit idle%0d valid", c), 32'(if4.out_valid), 32'd0);
      end

      // Re-entry restarts at position 0.
      mode = 2'd3;
      tick();
      tick();
      check("reentry k1 valid", 32'(if4.out_valid), 32'd0);
      tick();
      check("reentry data",  32'(if4.dataout),   32'h1);
      check("reentry valid", 32'(if4.out_valid), 32'd1);

      // Asynchronous reset mid-scan clears the output immediately.
      rst_n = 1'b0;
      #1;
      check("midscan rst valid", 32'(if4.out_valid), 32'd0);
      check("midscan rst data",  32'(if4.dataout),   32'd0);
      mode  = 2'd0;
      #2;
      rst_n = 1'b1;
      tick();
      check("post midscan rst valid", 32'(if4.out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
